fp_mul_rne_seq: RTL and testbench

//   Iterative IEEE-754 binary32 multiplier with round-to-nearest-even. Inverse of the FP divide

---
 rtl/fp_mul_rne_seq.sv | 202 ++++++++++++++++++++
 tb/tb_fp_mul_rne_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_rne_seq.sv
// Iterative binary32 multiplier with round-to-nearest-even.
// The mantissa product is built by shift-add, retiring BPC multiplier bits per
// cycle. Results and flags {NV,DZ,OF,UF,NX} hold until the next valid pulse.
//
// Handshake: start is sampled only while busy==0; a is operand A and b is
// operand B, both taken on the accepting edge. busy stays high from that edge
// until the result edge. valid pulses for exactly one cycle when y/flags
// change. A start in the valid cycle is accepted.
module fp_mul_rne_seq #(
    parameter int BPC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic [4:0]  flags,
    output logic        busy,
    output logic        valid
);

    localparam int N = 24 / BPC;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_RND} state_t;

    state_t      state, state_nx;

    // Latched operand fields and classification
    logic        sgn_q;
    logic [7:0]  ea_q, eb_q;
    logic        a_nan_q, a_snan_q, a_inf_q, a_zero_q;
    logic        b_nan_q, b_snan_q, b_inf_q, b_zero_q;

    // Shift-add datapath
    logic [47:0] acc;
    logic [47:0] mc;
    logic [23:0] mr;
    logic [4:0]  cnt;
    logic [47:0] part;

    // Input classification (denormals read as zero)
    logic        in_a_nan, in_a_snan, in_a_inf, in_a_zero;
    logic        in_b_nan, in_b_snan, in_b_inf, in_b_zero;
    logic [23:0] in_ma, in_mb;

    // Rounding path
    logic signed [10:0] e0, e1, e2;
    logic [23:0] m;
    logic        g, r, s, incr;
    logic [24:0] mr25;
    logic [22:0] mf;
    logic [31:0] res_y;
    logic [4:0]  res_f;

    assign busy = (state != S_IDLE);

    // Classify the operands presented on the inputs
    always_comb begin
        in_a_zero = (a[30:23] == 8'h00);
        in_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        in_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        in_a_snan = in_a_nan && !a[22];
        in_b_zero = (b[30:23] == 8'h00);
        in_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        in_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        in_b_snan = in_b_nan && !b[22];
        in_ma     = in_a_zero ? 24'd0 : {1'b1, a[22:0]};
        in_mb     = in_b_zero ? 24'd0 : {1'b1, b[22:0]};
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_MUL;
            S_MUL:  if (cnt == 5'(N - 1)) state_nx = S_RND;
            S_RND:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // One partial product: multiplicand times the low BPC multiplier bits
    always_comb begin
        part = mc * 48'(mr[BPC-1:0]);
    end

    // Operand capture and shift-add accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_q    <= 1'b0;
            ea_q     <= 8'd0;
            eb_q     <= 8'd0;
            a_nan_q  <= 1'b0;
            a_snan_q <= 1'b0;
            a_inf_q  <= 1'b0;
            a_zero_q <= 1'b0;
            b_nan_q  <= 1'b0;
            b_snan_q <= 1'b0;
            b_inf_q  <= 1'b0;
            b_zero_q <= 1'b0;
            acc      <= 48'd0;
            mc       <= 48'd0;
            mr       <= 24'd0;
            cnt      <= 5'd0;
        end else if (state == S_IDLE && start) begin
            sgn_q    <= a[31] ^ b[31];
            ea_q     <= a[30:23];
            eb_q     <= b[30:23];
            a_nan_q  <= in_a_nan;
            a_snan_q <= in_a_snan;
            a_inf_q  <= in_a_inf;
            a_zero_q <= in_a_zero;
            b_nan_q  <= in_b_nan;
            b_snan_q <= in_b_snan;
            b_inf_q  <= in_b_inf;
            b_zero_q <= in_b_zero;
            acc      <= 48'd0;
            mc       <= {24'd0, in_mb};
            mr       <= in_ma;
            cnt      <= 5'd0;
        end else if (state == S_MUL) begin
            acc <= acc + part;
            mc  <= mc << BPC;
            mr  <= mr >> BPC;
            cnt <= cnt + 5'd1;
        end
    end

    // Normalize, round to nearest even, and select the special-case result
    always_comb begin
        e0 = $signed({3'b000, ea_q}) + $signed({3'b000, eb_q}) - 11'sd127;
        if (acc[47]) begin
            m  = acc[47:24];
            g  = acc[23];
            r  = acc[22];
            s  = |acc[21:0];
            e1 = e0 + 11'sd1;
        end else begin
            m  = acc[46:23];
            g  = acc[22];
            r  = acc[21];
            s  = |acc[20:0];
            e1 = e0;
        end
        incr = (g & (r | s)) | (g & ~r & ~s & m[0]);
        mr25 = {1'b0, m} + {24'd0, incr};
        // A carry out of the rounded mantissa leaves 1.000..., so bump the exponent
        if (mr25[24]) begin
            mf = mr25[23:1];
            e2 = e1 + 11'sd1;
        end else begin
            mf = mr25[22:0];
            e2 = e1;
        end

        res_y = {sgn_q, 8'd0, mf};
        res_f = 5'b00000;
        if (a_nan_q || b_nan_q) begin
            res_y = 32'h7FC00000;
            res_f = {a_snan_q | b_snan_q, 4'b0000};
        end else if ((a_inf_q && b_zero_q) || (b_inf_q && a_zero_q)) begin
            res_y = 32'h7FC00000;
            res_f = 5'b10000;
        end else if (a_inf_q || b_inf_q) begin
            res_y = {sgn_q, 8'hFF, 23'd0};
        end else if (a_zero_q || b_zero_q) begin
            res_y = {sgn_q, 31'd0};
        end else if (e2 >= 11'sd255) begin
            res_y = {sgn_q, 8'hFF, 23'd0};
            res_f = 5'b00101;
        end else if (e2 <= 11'sd0) begin
            res_y = {sgn_q, 31'd0};
            res_f = 5'b00011;
        end else begin
            res_y = {sgn_q, e2[7:0], mf};
            res_f = {4'b0000, g | r | s};
        end
    end

    // Result registers, written only on the rounding cycle's exit edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= 32'd0;
            flags <= 5'd0;
            valid <= 1'b0;
        end else begin
            valid <= (state == S_RND);
            if (state == S_RND) begin
                y     <= res_y;
                flags <= res_f;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_rne_seq.sv
// Self-checking bench for fp_mul_rne_seq: scoreboard of expected results and
// expected valid times, fed by a driver and drained by an independent monitor.
module tb_fp_mul_rne_seq;

    localparam int BPC = 1;
    localparam int N   = 24 / BPC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] y;
    logic [4:0]  flags;
    logic        busy;
    logic        valid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [36:0] exp_q[$];
    int          exp_t[$];

    fp_mul_rne_seq #(.BPC(BPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .y     (y),
        .flags (flags),
        .busy  (busy),
        .valid (valid)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact integer product, rounded to 24 significant bits by
    // comparing the discarded remainder against one half ulp.
    function automatic logic [36:0] ref_mul(input logic [31:0] xa, input logic [31:0] xb);
        logic sa, sb, sg;
        int   ea, eb, e, sh, msb;
        longint fa, fb, p, q, rem, half;
        bit   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, nv, nx;
        sa = xa[31]; sb = xb[31]; sg = sa ^ sb;
        ea = int'(xa[30:23]); eb = int'(xb[30:23]);
        fa = longint'(xa[22:0]); fb = longint'(xb[22:0]);
        a_nan  = (ea == 255) && (fa != 0);
        b_nan  = (eb == 255) && (fb != 0);
        a_inf  = (ea == 255) && (fa == 0);
        b_inf  = (eb == 255) && (fb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) begin
            nv = (a_nan && !xa[22]) || (b_nan && !xb[22]);
            return {nv, 4'b0000, 32'h7FC00000};
        end
        if ((a_inf && b_zero) || (b_inf && a_zero)) return {5'b10000, 32'h7FC00000};
        if (a_inf || b_inf) return {5'b00000, sg, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {5'b00000, sg, 31'd0};
        p    = (fa + (longint'(1) << 23)) * (fb + (longint'(1) << 23));
        msb  = (p >= (longint'(1) << 47)) ? 47 : 46;
        sh   = msb - 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        e = ea + eb - 127 + (msb - 46);
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        nx = (rem != 0);
        if (e >= 255) return {5'b00101, sg, 8'hFF, 23'd0};
        if (e <= 0)   return {5'b00011, sg, 31'd0};
        return {4'b0000, nx, sg, 8'(e), q[22:0]};
    endfunction

    // Random operand spread across classes and exponent ranges
    function automatic logic [31:0] rand_fp();
        logic [31:0] rr;
        logic [22:0] fr;
        logic [7:0]  ex;
        rr = $urandom;
        fr = rr[22:0];
        case ($urandom_range(0, 11))
            0:  return {rr[31], 31'd0};
            1:  return {rr[31], 8'h00, fr | 23'd1};
            2:  return {rr[31], 8'hFF, 23'd0};
            3:  return {rr[31], 8'hFF, 1'b1, fr[21:0]};
            4:  return {rr[31], 8'hFF, 1'b0, fr[21:1], 1'b1};
            5:  begin ex = 8'($urandom_range(190, 254)); return {rr[31], ex, fr}; end
            6:  begin ex = 8'($urandom_range(1, 64));    return {rr[31], ex, fr}; end
            7:  return {rr[31], 8'($urandom_range(100, 154)), 23'h7FFFFF - 23'($urandom_range(0, 3))};
            default: begin ex = 8'($urandom_range(90, 164)); return {rr[31], ex, fr}; end
        endcase
    endfunction

    // Driver: wait for idle, present start for one edge, log the expectation
    task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input bit expect_it);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_wait: busy still 1 after %0d cycles, expected 0", guard);
        end
        start = 1'b1;
        a = xa;
        b = xb;
        @(posedge clk);
        #1;
        if (expect_it) begin
            exp_q.push_back(ref_mul(xa, xb));
            exp_t.push_back(cyc + N + 1);
        end
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
            exp_t.delete();
        end
    endtask

    // Monitor: compare every valid against the scoreboard; outputs must hold otherwise
    logic [31:0] prev_y;
    logic [4:0]  prev_f;
    logic        prev_v;
    initial begin
        logic [36:0] e;
        int t;
        prev_y = 32'd0;
        prev_f = 5'd0;
        prev_v = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_y = y;
                prev_f = flags;
                prev_v = 1'b0;
            end else if (valid) begin
                check("valid_consecutive", 64'(prev_v), 64'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: y=%08h flags=%05b, expected no result", y, flags);
                end else begin
                    e = exp_q.pop_front();
                    t = exp_t.pop_front();
                    check("result_y", 64'(y), 64'(e[31:0]));
                    check("result_flags", 64'(flags), 64'(e[36:32]));
                    check("latency", 64'(cyc), 64'(t));
                end
                prev_y = y;
                prev_f = flags;
                prev_v = 1'b1;
            end else begin
                check("hold", {27'd0, flags, y}, {27'd0, prev_f, prev_y});
                prev_v = 1'b0;
            end
        end
    end

    // Main sequence
    initial begin
        logic [31:0] da[10];
        logic [31:0] db[10];
        da = '{32'h3FC00000, 32'h3F800001, 32'hC0400000, 32'h7F000000, 32'h00800000,
               32'h7F800000, 32'h7FA00000, 32'hFF800000, 32'h80000000, 32'h7FC00001};
        db = '{32'h40000000, 32'h3F800001, 32'h40000000, 32'h40000000, 32'h3F000000,
               32'h00000000, 32'h3F800000, 32'h40400000, 32'h3F800000, 32'h00000000};

        repeat (3) @(posedge clk);
        #1;
        check("reset_y", 64'(y), 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, issued back to back
        for (int i = 0; i < 10; i++) issue(da[i], db[i], 1'b1);
        drain();

        // Start re-pulsed mid-multiply with other operands must be ignored
        issue(32'h3FC00000, 32'h40000000, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        a = 32'h40A00000;
        b = 32'h41200000;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Randomized traffic with occasional idle gaps
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
            issue(rand_fp(), rand_fp(), 1'b1);
        end
        drain();
        repeat (N + 4) @(negedge clk);

        // Asynchronous reset mid-multiply discards the operation
        issue(32'h40400000, 32'h40400000, 1'b0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_valid", 64'(valid), 64'd0);
        check("async_rst_y", 64'(y), 64'd0);
        check("async_rst_flags", 64'(flags), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 16) @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);

        // Recovery after reset
        issue(32'h3FC00000, 32'h40000000, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
